wrapper: RTL and testbench

Top-level system wrapper for the single-cycle RISC-V core: owns instruction ROM, data RAM, address decode and all memory-mapped peripheral registers. It connects board I/O (DIPs, push-buttons, LEDs, seven-segment, UART, OLED, accelerometer) to the core's load/store bus. It exposes PC bits [8:2] on `LED_PC` for program tracing.

---
 rtl/wrapper_pkg.sv | 87 ++++++++
 rtl/wrapper_RV.sv | 119 +++++++++++
 rtl/wrapper.sv | 149 ++++++++++++++
 tb/tb_wrapper.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/wrapper_pkg.sv
// Shared constants for the wrapper: memory map, MMIO offsets, opcodes, and the built-in colour-selector IROM image.
package wrapper_pkg;

    localparam logic [31:0] IROM_BASE  = 32'h0040_0000;
    localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam int          IROM_DEPTH = 128;
    localparam int          DMEM_DEPTH = 128;
    localparam int          IROM_AW    = $clog2(IROM_DEPTH);
    localparam int          DMEM_AW    = $clog2(DMEM_DEPTH);

    localparam logic [15:0] OFF_UART_RX      = 16'h0000;
    localparam logic [15:0] OFF_UART_TX      = 16'h0004;
    localparam logic [15:0] OFF_OLED_COL     = 16'h0020;
    localparam logic [15:0] OFF_OLED_ROW     = 16'h0024;
    localparam logic [15:0] OFF_OLED_DATA    = 16'h0028;
    localparam logic [15:0] OFF_ACCEL_DATA   = 16'h0040;
    localparam logic [15:0] OFF_ACCEL_DREADY = 16'h0044;
    localparam logic [15:0] OFF_LED          = 16'h0060;
    localparam logic [15:0] OFF_DIP          = 16'h0064;
    localparam logic [15:0] OFF_PB           = 16'h0068;
    localparam logic [15:0] OFF_SEVENSEG     = 16'h0080;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'h37,
        OPC_AUIPC  = 7'h17,
        OPC_JAL    = 7'h6F,
        OPC_JALR   = 7'h67,
        OPC_BRANCH = 7'h63,
        OPC_LOAD   = 7'h03,
        OPC_STORE  = 7'h23,
        OPC_OPIMM  = 7'h13,
        OPC_OP     = 7'h33
    } opcode_e;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    // Prologue sends one UART byte and one OLED pixel, then loops from 0x044 to 0x12C.
    function automatic logic [31:0] irom_word(input logic [6:0] idx);
        case (idx)
            7'd0:  return {20'hFFFF0, 5'd5, 7'h37};
            7'd1:  return enc_i(12'h041, 5'd0, 3'd0, 5'd6, 7'h13);
            7'd2:  return enc_s(12'h004, 5'd6, 5'd5);
            7'd3:  return {20'h00FF9, 5'd6, 7'h37};
            7'd4:  return enc_i(12'h800, 5'd6, 3'd0, 5'd6, 7'h13);
            7'd5:  return enc_s(12'h028, 5'd6, 5'd5);
            7'd6:  return enc_i(12'h000, 5'd0, 3'd0, 5'd7, 7'h13);
            7'd7:  return enc_i(12'h000, 5'd0, 3'd0, 5'd8, 7'h13);
            7'd17: return enc_i(12'h068, 5'd5, 3'd2, 5'd9, 7'h03);
            7'd18: return enc_i(12'h002, 5'd9, 3'd7, 5'd10, 7'h13);
            7'd19: return enc_b(13'h014, 5'd0, 5'd10, 3'd0);
            7'd20: return enc_i(12'h001, 5'd7, 3'd0, 5'd7, 7'h13);
            7'd21: return enc_i(12'h003, 5'd0, 3'd0, 5'd11, 7'h13);
            7'd22: return enc_b(13'h008, 5'd11, 5'd7, 3'd1);
            7'd23: return enc_i(12'h000, 5'd0, 3'd0, 5'd7, 7'h13);
            7'd24: return enc_i(12'h004, 5'd9, 3'd7, 5'd10, 7'h13);
            7'd25: return enc_b(13'h010, 5'd0, 5'd10, 3'd0);
            7'd26: return enc_i(12'h01F, 5'd0, 3'd0, 5'd11, 7'h13);
            7'd27: return enc_b(13'h008, 5'd11, 5'd8, 3'd0);
            7'd28: return enc_i(12'h001, 5'd8, 3'd0, 5'd8, 7'h13);
            7'd29: return enc_i(12'h001, 5'd9, 3'd7, 5'd10, 7'h13);
            7'd30: return enc_b(13'h00C, 5'd0, 5'd10, 3'd0);
            7'd31: return enc_b(13'h008, 5'd0, 5'd8, 3'd0);
            7'd32: return enc_i(12'hFFF, 5'd8, 3'd0, 5'd8, 7'h13);
            7'd33: return enc_i(12'h00B, 5'd8, 3'd1, 5'd12, 7'h13);
            7'd73: return enc_s(12'h080, 5'd12, 5'd5);
            7'd74: return enc_s(12'h060, 5'd7, 5'd5);
            7'd75: return 32'hF19F_F06F;
            default: return INSTR_NOP;
        endcase
    endfunction

endpackage

// File: rtl/wrapper_RV.sv
// Single-cycle RV32I core: fetch from Instr, combinational load/store bus, byte-enable stores.
module RV
    import wrapper_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] ReadData_in,
    output logic [31:0] PC,
    output logic        MemRead,
    output logic [3:0]  MemWrite_out,
    output logic [31:0] ComputeResult,
    output logic [31:0] WriteData_out
);
    logic [31:0] r_regs [32];
    opcode_e     w_opc;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_a, w_b, w_op_b, w_alu, w_addr, w_pc4, w_pc_next, w_wb, w_ld_sh, w_ld;
    logic        w_take, w_we_rd;

    assign w_opc   = opcode_e'(Instr[6:0]);
    assign w_rd    = Instr[11:7];
    assign w_f3    = Instr[14:12];
    assign w_rs1   = Instr[19:15];
    assign w_rs2   = Instr[24:20];
    assign w_imm_i = {{20{Instr[31]}}, Instr[31:20]};
    assign w_imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
    assign w_imm_b = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
    assign w_imm_u = {Instr[31:12], 12'b0};
    assign w_imm_j = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
    assign w_a     = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_b     = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_op_b  = (w_opc == OPC_OP) ? w_b : w_imm_i;
    assign w_addr  = w_a + ((w_opc == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_pc4   = PC + 32'd4;
    assign w_ld_sh = ReadData_in >> {w_addr[1:0], 3'b000};

    assign MemRead       = (w_opc == OPC_LOAD);
    assign ComputeResult = (w_opc == OPC_LOAD || w_opc == OPC_STORE) ? w_addr : w_alu;

    always_comb begin
        w_alu = '0;
        case (w_f3)
            3'd0: w_alu = (w_opc == OPC_OP && Instr[30]) ? w_a - w_op_b : w_a + w_op_b;
            3'd1: w_alu = w_a << w_op_b[4:0];
            3'd2: w_alu = {31'b0, $signed(w_a) < $signed(w_op_b)};
            3'd3: w_alu = {31'b0, w_a < w_op_b};
            3'd4: w_alu = w_a ^ w_op_b;
            3'd5: w_alu = Instr[30] ? $signed(w_a) >>> w_op_b[4:0] : w_a >> w_op_b[4:0];
            3'd6: w_alu = w_a | w_op_b;
            default: w_alu = w_a & w_op_b;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            3'd0: w_take = (w_a == w_b);
            3'd1: w_take = (w_a != w_b);
            3'd4: w_take = ($signed(w_a) < $signed(w_b));
            3'd5: w_take = ($signed(w_a) >= $signed(w_b));
            3'd6: w_take = (w_a < w_b);
            3'd7: w_take = (w_a >= w_b);
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_ld = ReadData_in;
        case (w_f3)
            3'd0: w_ld = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
            3'd1: w_ld = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
            3'd4: w_ld = {24'b0, w_ld_sh[7:0]};
            3'd5: w_ld = {16'b0, w_ld_sh[15:0]};
            default: w_ld = ReadData_in;
        endcase
    end

    // Sub-word stores replicate the data across lanes; the byte enables pick the lane.
    always_comb begin
        MemWrite_out  = '0;
        WriteData_out = w_b;
        if (w_opc == OPC_STORE) begin
            case (w_f3)
                3'd0: begin MemWrite_out = 4'b0001 << w_addr[1:0]; WriteData_out = {4{w_b[7:0]}}; end
                3'd1: begin MemWrite_out = 4'b0011 << w_addr[1:0]; WriteData_out = {2{w_b[15:0]}}; end
                default: MemWrite_out = 4'b1111;
            endcase
        end
    end

    always_comb begin
        w_pc_next = w_pc4;
        w_wb      = w_alu;
        w_we_rd   = 1'b0;
        case (w_opc)
            OPC_LUI:    begin w_wb = w_imm_u;      w_we_rd = 1'b1; end
            OPC_AUIPC:  begin w_wb = PC + w_imm_u; w_we_rd = 1'b1; end
            OPC_JAL:    begin w_wb = w_pc4; w_pc_next = PC + w_imm_j; w_we_rd = 1'b1; end
            OPC_JALR:   begin w_wb = w_pc4; w_pc_next = (w_a + w_imm_i) & ~32'd1; w_we_rd = 1'b1; end
            OPC_BRANCH: if (w_take) w_pc_next = PC + w_imm_b;
            OPC_LOAD:   begin w_wb = w_ld; w_we_rd = 1'b1; end
            OPC_OPIMM, OPC_OP: w_we_rd = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) PC <= IROM_BASE;
        else        PC <= w_pc_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET && w_we_rd && w_rd != 5'd0) r_regs[w_rd] <= w_wb;
    end

endmodule

// File: rtl/wrapper.sv
// System wrapper: IROM, byte-enabled DMEM, MMIO peripherals around the RV core.
// WRAPPER_UART_EN enables the UART TX/RX registers and handshake; without it they read/drive 0.
module wrapper
    import wrapper_pkg::*;
#(
    parameter int N_LEDs_OUT = 8,
    parameter int N_DIPs     = 16,
    parameter int N_PBs      = 3,
    parameter     IROM_INIT  = "AA_IROM.mem",
    parameter     DMEM_INIT  = "AA_DMEM.mem"
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_DIPs-1:0]     DIP,
    input  logic [N_PBs-1:0]      PB,
    output logic [N_LEDs_OUT-1:0] LED_OUT,
    output logic [6:0]            LED_PC,
    output logic [31:0]           SEVENSEGHEX,
    output logic [7:0]            UART_TX,
    input  logic                  UART_TX_ready,
    output logic                  UART_TX_valid,
    input  logic [7:0]            UART_RX,
    input  logic                  UART_RX_valid,
    output logic                  UART_RX_ack,
    output logic                  OLED_Write,
    output logic [6:0]            OLED_Col,
    output logic [5:0]            OLED_Row,
    output logic [23:0]           OLED_Data,
    input  logic [31:0]           ACCEL_Data,
    input  logic                  ACCEL_DReady
);
    logic                  r_rst_sync, w_rst_n;
    logic [31:0]           w_pc, w_instr, w_rdata, w_addr, w_wdata, w_mmio_rd, w_uart_rd;
    logic                  w_mem_rd, w_is_dmem, w_is_mmio, w_mmio_wr, w_unused, w_unused_uart;
    logic [3:0]            w_be;
    logic [15:0]           w_off;
    logic [31:0]           r_dmem [DMEM_DEPTH];
    logic [N_LEDs_OUT-1:0] r_led;
    logic [31:0]           r_seg;
    logic [6:0]            r_oled_col;
    logic [5:0]            r_oled_row;
    logic [23:0]           r_oled_data;
    logic                  r_oled_wr;

    // The built-in ROM image stands in for the IROM_INIT/DMEM_INIT files.
    assign w_unused = ^{IROM_INIT, DMEM_INIT, w_pc[31:IROM_AW+2], w_pc[1:0]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_rst_sync <= 1'b0;
        else        r_rst_sync <= 1'b1;
    end
    assign w_rst_n = r_rst_sync;

    RV u_rv (
        .CLK(CLK), .RESET(w_rst_n), .Instr(w_instr), .PC(w_pc), .ReadData_in(w_rdata),
        .MemRead(w_mem_rd), .MemWrite_out(w_be), .ComputeResult(w_addr), .WriteData_out(w_wdata)
    );

    assign w_instr   = irom_word(w_pc[IROM_AW+1:2]);
    assign LED_PC    = w_pc[8:2];
    assign w_is_dmem = (w_addr[31:DMEM_AW+2] == DMEM_BASE[31:DMEM_AW+2]);
    assign w_is_mmio = (w_addr[31:16] == MMIO_BASE[31:16]);
    assign w_off     = w_addr[15:0];
    assign w_mmio_wr = w_is_mmio && (|w_be);

    always_comb begin
        w_mmio_rd = '0;
        case (w_off)
            OFF_UART_RX:      w_mmio_rd = w_uart_rd;
            OFF_ACCEL_DATA:   w_mmio_rd = ACCEL_Data;
            OFF_ACCEL_DREADY: w_mmio_rd = {31'b0, ACCEL_DReady};
            OFF_DIP:          w_mmio_rd = 32'(DIP);
            OFF_PB:           w_mmio_rd = 32'(PB);
            default:          w_mmio_rd = '0;
        endcase
        w_rdata = w_is_dmem ? r_dmem[w_addr[DMEM_AW+1:2]] : (w_is_mmio ? w_mmio_rd : '0);
    end

    // DMEM has no reset so its contents survive RESET; stores are blocked while reset is held.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (w_rst_n && w_is_dmem && w_be[b])
                r_dmem[w_addr[DMEM_AW+1:2]][8*b +: 8] <= w_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_led       <= '0;
            r_seg       <= '0;
            r_oled_col  <= '0;
            r_oled_row  <= '0;
            r_oled_data <= '0;
            r_oled_wr   <= 1'b0;
        end else begin
            r_oled_wr <= 1'b0;
            if (w_mmio_wr) begin
                case (w_off)
                    OFF_LED:       r_led      <= w_wdata[N_LEDs_OUT-1:0];
                    OFF_SEVENSEG:  r_seg      <= w_wdata;
                    OFF_OLED_COL:  r_oled_col <= w_wdata[6:0];
                    OFF_OLED_ROW:  r_oled_row <= w_wdata[5:0];
                    OFF_OLED_DATA: begin r_oled_data <= w_wdata[23:0]; r_oled_wr <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign LED_OUT     = r_led;
    assign SEVENSEGHEX = r_seg;
    assign OLED_Col    = r_oled_col;
    assign OLED_Row    = r_oled_row;
    assign OLED_Data   = r_oled_data;
    assign OLED_Write  = r_oled_wr;

`ifdef WRAPPER_UART_EN
    logic [7:0] r_uart_tx;
    logic       r_tx_valid, r_rx_ack;

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_uart_tx  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ack   <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_rx_ack   <= w_mem_rd && w_is_mmio && (w_off == OFF_UART_RX) && UART_RX_valid;
            if (w_mmio_wr && (w_off == OFF_UART_TX) && UART_TX_ready) begin
                r_uart_tx  <= w_wdata[7:0];
                r_tx_valid <= 1'b1;
            end
        end
    end

    assign w_uart_rd     = UART_RX_valid ? {24'b0, UART_RX} : '0;
    assign UART_TX       = r_uart_tx;
    assign UART_TX_valid = r_tx_valid;
    assign UART_RX_ack   = r_rx_ack;
    assign w_unused_uart = 1'b0;
`else
    assign w_uart_rd     = '0;
    assign UART_TX       = '0;
    assign UART_TX_valid = 1'b0;
    assign UART_RX_ack   = 1'b0;
    assign w_unused_uart = ^{UART_TX_ready, UART_RX, UART_RX_valid, w_mem_rd};
`endif

endmodule

// File: tb/tb_wrapper.sv
// Scoreboard bench for wrapper running the built-in colour-selector program.
module tb_wrapper;
    logic        CLK, RESET;
    logic [15:0] DIP;
    logic [2:0]  PB;
    logic [7:0]  LED_OUT;
    logic [6:0]  LED_PC;
    logic [31:0] SEVENSEGHEX;
    logic [7:0]  UART_TX, UART_RX;
    logic        UART_TX_ready, UART_TX_valid, UART_RX_valid, UART_RX_ack;
    logic        OLED_Write;
    logic [6:0]  OLED_Col;
    logic [5:0]  OLED_Row;
    logic [23:0] OLED_Data;
    logic [31:0] ACCEL_Data;
    logic        ACCEL_DReady;

    wrapper dut (
        .CLK(CLK), .RESET(RESET), .DIP(DIP), .PB(PB), .LED_OUT(LED_OUT), .LED_PC(LED_PC),
        .SEVENSEGHEX(SEVENSEGHEX), .UART_TX(UART_TX), .UART_TX_ready(UART_TX_ready),
        .UART_TX_valid(UART_TX_valid), .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid),
        .UART_RX_ack(UART_RX_ack), .OLED_Write(OLED_Write), .OLED_Col(OLED_Col), .OLED_Row(OLED_Row),
        .OLED_Data(OLED_Data), .ACCEL_Data(ACCEL_Data), .ACCEL_DReady(ACCEL_DReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef WRAPPER_UART_EN
    localparam int          EXP_UART_PULSES = 1;
    localparam logic [31:0] EXP_UART_TX     = 32'h41;
`else
    localparam int          EXP_UART_PULSES = 0;
    localparam logic [31:0] EXP_UART_TX     = 32'h0;
`endif

    int          n_tests = 0, n_fail = 0;
    int          n_samples = 0, uart_pulses = 0, oled_pulses = 0;
    int          m_led = 0, m_seg = 0;
    bit          mon_en = 1'b0;
    logic [31:0] seg_q[$], led_q[$], uart_q[$], oled_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // PB is loaded at PC 0x044 (LED_PC 17); SEVENSEG shows at LED_PC 74, LED at 75.
    always @(negedge CLK) begin
        if (RESET) begin
            if (mon_en && LED_PC == 7'd17) begin
                if (PB[1]) m_led = (m_led == 2) ? 0 : m_led + 1;
                if (PB[2] && m_seg != 31) m_seg = m_seg + 1;
                if (PB[0] && m_seg != 0)  m_seg = m_seg - 1;
                seg_q.push_back(32'(m_seg) << 11);
                led_q.push_back(32'(m_led));
                n_samples++;
            end
            if (LED_PC == 7'd74) begin
                if (seg_q.size() > 0) chk("sevenseg", SEVENSEGHEX, seg_q.pop_front());
                else if (mon_en)      chk("seg_q_underflow", seg_q.size(), 1);
            end
            if (LED_PC == 7'd75) begin
                if (led_q.size() > 0) chk("led_out", {24'b0, LED_OUT}, led_q.pop_front());
                else if (mon_en)      chk("led_q_underflow", led_q.size(), 1);
            end
            if (UART_TX_valid) begin
                uart_pulses++;
                if (uart_q.size() > 0) chk("uart_tx", {24'b0, UART_TX}, uart_q.pop_front());
            end
            if (OLED_Write) begin
                oled_pulses++;
                if (oled_q.size() > 0) chk("oled_data", {8'b0, OLED_Data}, oled_q.pop_front());
            end
        end
    end

    task automatic run_iters(input int n, input logic [2:0] pb);
        int start, cyc;
        @(posedge CLK);
        #2 PB = pb;
        start = n_samples;
        cyc = 0;
        while (n_samples < start + n && cyc < n * 70 + 100) begin
            @(negedge CLK);
            #1 cyc++;
        end
        chk("loop_progress", n_samples - start, n);
    endtask

    initial begin
        int cyc;
        RESET = 1'b1; DIP = 16'h1234; PB = 3'b000; UART_TX_ready = 1'b1;
        UART_RX = 8'h5A; UART_RX_valid = 1'b0; ACCEL_Data = 32'h0; ACCEL_DReady = 1'b0;
`ifdef WRAPPER_UART_EN
        uart_q.push_back(32'h41);
`endif
        oled_q.push_back(32'h00FF8800);

        #1 RESET = 1'b0;
        #2;
        chk("rst_led_pc", {25'b0, LED_PC}, 32'h0);
        chk("rst_led_out", {24'b0, LED_OUT}, 32'h0);
        chk("rst_sevenseg", SEVENSEGHEX, 32'h0);
        chk("rst_uart_valid", {31'b0, UART_TX_valid}, 32'h0);
        chk("rst_oled_write", {31'b0, OLED_Write}, 32'h0);
        chk("rst_rx_ack", {31'b0, UART_RX_ack}, 32'h0);
        #8 RESET = 1'b1;
        mon_en = 1'b1;

        cyc = 0;
        while (LED_PC == 7'd0 && cyc < 20) begin
            @(negedge CLK);
            #1 cyc++;
        end
        chk("led_pc_first", {25'b0, LED_PC}, 32'd1);
        @(negedge CLK); #1 chk("led_pc_step2", {25'b0, LED_PC}, 32'd2);
        @(negedge CLK); #1 chk("led_pc_step3", {25'b0, LED_PC}, 32'd3);
        chk("led_out_pre_store", {24'b0, LED_OUT}, 32'h0);
        chk("sevenseg_pre_store", SEVENSEGHEX, 32'h0);

        run_iters(4, 3'b010);
        run_iters(33, 3'b100);
        chk("seg_sat_hi", SEVENSEGHEX, 32'd31 << 11);
        run_iters(2, 3'b000);
        run_iters(33, 3'b001);
        chk("seg_sat_lo", SEVENSEGHEX, 32'h0);
        run_iters(2, 3'b000);
        mon_en = 1'b0;

        cyc = 0;
        while ((seg_q.size() > 0 || led_q.size() > 0) && cyc < 200) begin
            @(negedge CLK);
            #1 cyc++;
        end
        chk("seg_q_drained", seg_q.size(), 0);
        chk("led_q_drained", led_q.size(), 0);
        chk("uart_valid_cycles", uart_pulses, EXP_UART_PULSES);
        chk("uart_tx_hold", {24'b0, UART_TX}, EXP_UART_TX);
        chk("uart_q_drained", uart_q.size(), 0);
        chk("oled_write_cycles", oled_pulses, 1);
        chk("oled_q_drained", oled_q.size(), 0);
        chk("oled_col_hold", {25'b0, OLED_Col}, 32'h0);
        chk("oled_row_hold", {26'b0, OLED_Row}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
